// File: rtl/pattern_gen.sv
// pattern_gen: loads a sample pattern from an AXI-Stream slave into a local
// buffer and replays it on dout at a programmable divided rate.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN        clock, async active-low reset
//   S_AXIS_TDATA/TVALID/TLAST/TREADY  pattern load stream (slave)
//   start, abort, clr                 control pulses
//   ckdiv                             sample period minus 1, in clocks
//   loops                             passes to play, 0 = until abort
//   idle_level                        dout value while not playing
//   dout, dout_en, sample_tick        playback outputs
//   loaded, busy, done, truncated     status
//   pattern_len                       number of stored samples
module pattern_gen #(
   parameter int unsigned SIZE    = 32,
   parameter int unsigned MAX_DIV = 32,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LOOP_W  = 16
) (
   input  logic                       S_AXI_ACLK,
   input  logic                       S_AXI_ARESETN,
   input  logic [SIZE-1:0]            S_AXIS_TDATA,
   input  logic                       S_AXIS_TVALID,
   input  logic                       S_AXIS_TLAST,
   output logic                       S_AXIS_TREADY,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       clr,
   input  logic [$clog2(MAX_DIV)-1:0] ckdiv,
   input  logic [LOOP_W-1:0]          loops,
   input  logic [SIZE-1:0]            idle_level,
   output logic [SIZE-1:0]            dout,
   output logic                       dout_en,
   output logic                       sample_tick,
   output logic                       loaded,
   output logic                       busy,
   output logic                       done,
   output logic                       truncated,
   output logic [$clog2(DEPTH):0]     pattern_len
);

   localparam int unsigned CW = $clog2(MAX_DIV);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_READY = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   state_e            state_q, state_d;

   logic [SIZE-1:0]   mem_q [DEPTH];
   logic [SIZE-1:0]   rdata_q;
   logic              we_c;
   logic [AW-1:0]     waddr_c;
   logic [AW-1:0]     raddr_c;

   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     plen_q, plen_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     div_q, div_d;
   logic [CW-1:0]     ckdiv_q, ckdiv_d;
   logic [LOOP_W-1:0] loops_q, loops_d;
   logic [LOOP_W-1:0] pass_q, pass_d;
   logic [SIZE-1:0]   dout_q, dout_d;
   logic              dout_en_q, dout_en_d;
   logic              tick_q, tick_d;
   logic              trunc_q, trunc_d;
   logic              done_q, done_d;
   logic              tready_q, tready_d;
   logic              loaded_q, loaded_d;
   logic              busy_q, busy_d;

   logic              beat_c;
   logic              full_c;
   logic [AW-1:0]     last_idx_c;
   logic              period_end_c;
   logic              pass_end_c;
   logic [LOOP_W-1:0] pass_inc_c;
   logic              finish_c;

   // Next playback index with wrap at the last stored sample.
   function automatic logic [AW-1:0] nxt_idx(input logic [AW-1:0] i,
                                             input logic [AW-1:0] last);
      return (i == last) ? '0 : AW'(i + AW'(1));
   endfunction

   assign beat_c       = S_AXIS_TVALID && tready_q;
   assign full_c       = (wptr_q == PW'(DEPTH - 1));
   assign last_idx_c   = AW'(plen_q - PW'(1));
   assign period_end_c = (div_q == ckdiv_q);
   assign pass_end_c   = period_end_c && (idx_q == last_idx_c);
   assign pass_inc_c   = (&pass_q) ? pass_q : LOOP_W'(pass_q + LOOP_W'(1));
   assign finish_c     = pass_end_c && (loops_q != '0) && (pass_inc_c == loops_q);

   assign waddr_c = wptr_q[AW-1:0];
   // Prefetch: read the sample that follows the one dout holds next cycle,
   // and sample 0 whenever not running so a start always finds it ready.
   assign raddr_c = (state_d == ST_RUN) ? nxt_idx(idx_d, last_idx_c) : '0;

   // Pattern buffer: synchronous-read RAM, write-first on an address clash.
   always_ff @(posedge S_AXI_ACLK) begin
      if (we_c) begin
         mem_q[waddr_c] <= S_AXIS_TDATA;
      end
      rdata_q <= (we_c && (waddr_c == raddr_c)) ? S_AXIS_TDATA : mem_q[raddr_c];
   end

   // State register.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort beats start, clr beats both when stopped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (beat_c) begin
               state_d = (S_AXIS_TLAST || full_c) ? ST_READY : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (abort || clr) begin
               state_d = ST_IDLE;
            end else if (beat_c && (S_AXIS_TLAST || full_c)) begin
               state_d = ST_READY;
            end
         end
         ST_READY, ST_DONE: begin
            if (clr) begin
               state_d = ST_IDLE;
            end else if (abort) begin
               state_d = ST_DONE;
            end else if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort || finish_c) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and output next values.
   always_comb begin
      we_c      = 1'b0;
      wptr_d    = wptr_q;
      plen_d    = plen_q;
      idx_d     = idx_q;
      div_d     = div_q;
      ckdiv_d   = ckdiv_q;
      loops_d   = loops_q;
      pass_d    = pass_q;
      trunc_d   = trunc_q;
      done_d    = done_q;
      dout_d    = idle_level;
      dout_en_d = 1'b0;
      tick_d    = 1'b0;
      case (state_q)
         ST_IDLE, ST_LOAD: begin
            if (beat_c) begin
               we_c   = 1'b1;
               wptr_d = PW'(wptr_q + PW'(1));
               if (state_d == ST_READY) begin
                  plen_d  = PW'(wptr_q + PW'(1));
                  trunc_d = !S_AXIS_TLAST;
               end
            end
            // Abandoned load: discard whatever was written.
            if ((state_q == ST_LOAD) && (abort || clr)) begin
               wptr_d = '0;
            end
         end
         ST_READY, ST_DONE: begin
            if (clr) begin
               wptr_d  = '0;
               plen_d  = '0;
               trunc_d = 1'b0;
               done_d  = 1'b0;
            end else if (abort) begin
               done_d = 1'b1;
            end else if (start) begin
               ckdiv_d   = ckdiv;
               loops_d   = loops;
               done_d    = 1'b0;
               pass_d    = '0;
               div_d     = '0;
               idx_d     = '0;
               dout_d    = rdata_q;
               dout_en_d = 1'b1;
               tick_d    = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort || finish_c) begin
               done_d = 1'b1;
            end else begin
               dout_en_d = 1'b1;
               if (period_end_c) begin
                  div_d  = '0;
                  idx_d  = nxt_idx(idx_q, last_idx_c);
                  dout_d = rdata_q;
                  tick_d = 1'b1;
                  if (pass_end_c) begin
                     pass_d = pass_inc_c;
                  end
               end else begin
                  div_d  = CW'(div_q + CW'(1));
                  dout_d = dout_q;
               end
            end
         end
         default: ;
      endcase
      tready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
      loaded_d = (state_d == ST_READY) || (state_d == ST_RUN) || (state_d == ST_DONE);
      busy_d   = (state_d == ST_RUN);
   end

   // Datapath and output registers.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wptr_q    <= '0;
         plen_q    <= '0;
         idx_q     <= '0;
         div_q     <= '0;
         ckdiv_q   <= '0;
         loops_q   <= '0;
         pass_q    <= '0;
         dout_q    <= '0;
         dout_en_q <= 1'b0;
         tick_q    <= 1'b0;
         trunc_q   <= 1'b0;
         done_q    <= 1'b0;
         tready_q  <= 1'b0;
         loaded_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         plen_q    <= plen_d;
         idx_q     <= idx_d;
         div_q     <= div_d;
         ckdiv_q   <= ckdiv_d;
         loops_q   <= loops_d;
         pass_q    <= pass_d;
         dout_q    <= dout_d;
         dout_en_q <= dout_en_d;
         tick_q    <= tick_d;
         trunc_q   <= trunc_d;
         done_q    <= done_d;
         tready_q  <= tready_d;
         loaded_q  <= loaded_d;
         busy_q    <= busy_d;
      end
   end

   assign S_AXIS_TREADY = tready_q;
   assign dout          = dout_q;
   assign dout_en       = dout_en_q;
   assign sample_tick   = tick_q;
   assign loaded        = loaded_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign truncated     = trunc_q;
   assign pattern_len   = plen_q;

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed + randomized bench for pattern_gen. The expected
// playback stream is derived arithmetically from the stored pattern, ckdiv
// and loops (sample j/(ckdiv+1) mod len, tick on period boundaries).
module tb_pattern_gen;

   localparam int unsigned SIZE    = 32;
   localparam int unsigned MAX_DIV = 32;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned LOOP_W  = 16;
   localparam int unsigned CW      = $clog2(MAX_DIV);
   localparam int unsigned LW      = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [SIZE-1:0]   tdata = '0;
   logic              tvalid = 1'b0;
   logic              tlast = 1'b0;
   logic              tready;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              clr = 1'b0;
   logic [CW-1:0]     ckdiv = '0;
   logic [LOOP_W-1:0] loops = '0;
   logic [SIZE-1:0]   idle_level = '0;
   logic [SIZE-1:0]   dout;
   logic              dout_en;
   logic              sample_tick;
   logic              loaded;
   logic              busy;
   logic              done;
   logic              truncated;
   logic [LW-1:0]     pattern_len;

   int total = 0;
   int bad   = 0;
   logic [SIZE-1:0] pat [$];

   always #5 clk = ~clk;

   pattern_gen #(
      .SIZE    (SIZE),
      .MAX_DIV (MAX_DIV),
      .DEPTH   (DEPTH),
      .LOOP_W  (LOOP_W)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXIS_TDATA  (tdata),
      .S_AXIS_TVALID (tvalid),
      .S_AXIS_TLAST  (tlast),
      .S_AXIS_TREADY (tready),
      .start         (start),
      .abort         (abort),
      .clr           (clr),
      .ckdiv         (ckdiv),
      .loops         (loops),
      .idle_level    (idle_level),
      .dout          (dout),
      .dout_en       (dout_en),
      .sample_tick   (sample_tick),
      .loaded        (loaded),
      .busy          (busy),
      .done          (done),
      .truncated     (truncated),
      .pattern_len   (pattern_len)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One stream beat, waiting (bounded) for TREADY.
   task automatic send_beat(input logic [SIZE-1:0] d, input logic last);
      int n;
      n = 0;
      tvalid = 1'b1;
      tdata  = d;
      tlast  = last;
      while (!tready && n < 50) begin
         step();
         n++;
      end
      check("tready_wait", 64'(tready), 64'(1));
      step();
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   // Streams the bench copy of the pattern, TLAST on the final beat if asked.
   task automatic send_pat(input logic with_last);
      for (int i = 0; i < pat.size(); i++) begin
         send_beat(pat[i], with_last && (i == pat.size() - 1));
      end
   endtask

   task automatic rand_pat(input int len);
      pat.delete();
      for (int i = 0; i < len; i++) pat.push_back(SIZE'($urandom));
   endtask

   task automatic chk_loaded(input string tag, input int len, input logic trunc);
      check(tag, {loaded, busy, tready, truncated, pattern_len},
            {1'b1, 1'b0, 1'b0, trunc, LW'(len)});
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   // Starts playback and checks every cycle against the arithmetic model.
   // abort_at < 0 means no abort; otherwise abort is driven at that sample slot.
   task automatic play(input string tag, input int ck, input int lp, input int abort_at);
      int len;
      int per;
      int tot;
      logic [SIZE-1:0] idle;
      logic exp_tick;
      len  = pat.size();
      per  = ck + 1;
      tot  = lp * len * per;
      idle = SIZE'($urandom);
      idle_level = idle;
      ckdiv = CW'(ck);
      loops = LOOP_W'(lp);
      start = 1'b1;
      step();
      start = 1'b0;
      // Changes during the run must have no effect.
      ckdiv = CW'($urandom);
      loops = LOOP_W'($urandom_range(1, 5));
      for (int j = 0; j < 2000; j++) begin
         if (lp != 0 && j == tot) begin
            check({tag, "_end"}, {dout, dout_en, sample_tick, busy, done, loaded},
                  {idle, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
            return;
         end
         exp_tick = ((j % per) == 0);
         check(tag, {dout, dout_en, sample_tick, busy, done, loaded},
               {pat[(j / per) % len], 1'b1, exp_tick, 1'b1, 1'b0, 1'b1});
         if (j == abort_at) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            check({tag, "_abort"}, {dout, dout_en, sample_tick, busy, done, loaded},
                  {idle, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
            return;
         end
         step();
      end
      check({tag, "_bound"}, 64'(busy), 64'(0));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SIZE-1:0] b9;
      logic [SIZE-1:0] b10;
      int len;

      // Reset values.
      idle_level = 32'h5A5A_0F0F;
      step();
      step();
      check("reset_outs", {dout, dout_en, sample_tick, loaded, busy, done, truncated, tready, pattern_len},
            '0);
      rst_n = 1'b1;
      step();
      check("post_reset", {tready, loaded, busy, dout}, {1'b1, 1'b0, 1'b0, 32'h5A5A_0F0F});

      // Four-beat pattern, back-to-back samples, two passes.
      pat.delete();
      pat.push_back(32'hA);
      pat.push_back(32'hB);
      pat.push_back(32'hC);
      pat.push_back(32'hD);
      send_pat(1'b1);
      chk_loaded("load4", 4, 1'b0);
      play("p_div0_x2", 0, 2, -1);
      check("len4_after", {pattern_len, truncated}, {LW'(4), 1'b0});

      // Same pattern, each sample held four clocks, one pass (restart from DONE).
      play("p_div3_x1", 3, 1, -1);

      // Overfill without TLAST: eight accepted, rest back-pressured.
      pulse_clr();
      rand_pat(DEPTH);
      send_pat(1'b0);
      chk_loaded("trunc_load", DEPTH, 1'b1);
      b9  = SIZE'($urandom);
      b10 = SIZE'($urandom);
      tvalid = 1'b1;
      tdata  = b9;
      tlast  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("pending_hold", {tready, pattern_len}, {1'b0, LW'(DEPTH)});
      end
      play("p_full", 0, 1, -1);
      check("pending_after_play", {tready, truncated}, {1'b0, 1'b1});
      pulse_clr();
      check("clr_pending", {tready, loaded, truncated, pattern_len}, {1'b1, 1'b0, 1'b0, LW'(0)});
      pat.delete();
      pat.push_back(b9);
      pat.push_back(b10);
      send_pat(1'b1);
      chk_loaded("pending_load", 2, 1'b0);
      play("p_pending", 0, 2, -1);

      // Endless loop on three samples, abort at the 20th clock, then replay.
      pulse_clr();
      rand_pat(3);
      send_pat(1'b1);
      chk_loaded("load3", 3, 1'b0);
      play("p_inf", 1, 0, 19);
      play("p_restart", 1, 1, -1);

      // start and abort together from READY, then clr.
      pulse_clr();
      rand_pat(2);
      send_pat(1'b1);
      idle_level = SIZE'($urandom);
      step();
      step();
      check("ready_idle", {dout, dout_en, busy, done}, {idle_level, 1'b0, 1'b0, 1'b0});
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort", {busy, dout_en, done, loaded, sample_tick, dout},
            {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, idle_level});
      step();
      check("start_abort_hold", {busy, dout_en, done}, {1'b0, 1'b0, 1'b1});
      pulse_clr();
      check("clr_to_idle", {loaded, tready, done, pattern_len, truncated},
            {1'b0, 1'b1, 1'b0, LW'(0), 1'b0});

      // Randomized patterns, including single-sample and exactly-full with TLAST.
      for (int it = 0; it < 5; it++) begin
         if (it == 0) len = 1;
         else if (it == 1) len = DEPTH;
         else len = $urandom_range(2, DEPTH);
         pulse_clr();
         rand_pat(len);
         send_pat(1'b1);
         chk_loaded("rnd_load", len, 1'b0);
         play("p_rnd", $urandom_range(0, 3), $urandom_range(1, 3),
              (it == 4) ? $urandom_range(0, 5) : -1);
      end

      // Asynchronous reset in the middle of a run.
      pulse_clr();
      rand_pat(4);
      send_pat(1'b1);
      ckdiv = CW'(1);
      loops = LOOP_W'(0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      check("pre_reset_run", {busy, dout_en}, {1'b1, 1'b1});
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset", {dout, dout_en, loaded, busy, tready, sample_tick, done},
            '0);
      step();
      rst_n = 1'b1;
      idle_level = SIZE'($urandom);
      step();
      check("after_reset", {loaded, busy, tready, pattern_len, dout},
            {1'b0, 1'b0, 1'b1, LW'(0), idle_level});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Stimulus-generator counterpart of the capture path: accepts a pattern over an AXI-Stream slave into an internal buffer, then replays it on output pins at a divided rate.
- Supports loop count, abort and a programmable idle level.
- Sits beside the capture core in the logic analyzer top; control and status signals are driven by the AXI-MM register slave.
- Single clock domain.

Parameters:
size, 32, width of pattern sample and dout
max_div, 32, maximum clock divider; ckdiv width is $clog2(max_div)
depth, 256, pattern buffer entries (power of 2, >=2)
loop_w, 16, loop counter width

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXIS_TDATA  in  size  pattern sample
S_AXIS_TVALID  in  1  sample valid
S_AXIS_TLAST  in  1  last sample of pattern
S_AXIS_TREADY  out  1  buffer accepting
start  in  1  pulse: begin playback
abort  in  1  pulse: stop playback / discard load
clr  in  1  pulse: empty buffer
ckdiv  in  $clog2(max_div)  sample period minus 1, in clocks
loops  in  loop_w  passes to play; 0 = infinite
idle_level  in  size  dout value when not playing
dout  out  size  generated pattern
dout_en  out  1  high while playing (output-enable)
sample_tick  out  1  1-cycle pulse when dout takes a new sample
loaded  out  1  pattern present (READY/RUN/DONE)
busy  out  1  state == RUN
done  out  1  playback finished or aborted; held until start/clr
truncated  out  1  buffer filled before TLAST
pattern_len  out  $clog2(depth)+1  stored sample count

Behaviour:
- Reset (async, S_AXI_ARESETN low):
  - state=IDLE; all outputs 0 except dout=0.
  - Pointers, counters and pattern_len cleared.
  - Reset may assert mid-load or mid-run with no glitch requirement beyond immediate clear.
- States: IDLE, LOAD, READY, RUN, DONE.
- S_AXIS_TREADY = 1 only in IDLE or LOAD with wptr<depth.
- Beat accept (TVALID&&TREADY):
  - mem[wptr]<=TDATA, wptr++; IDLE->LOAD on first beat.
  - On TLAST, or on the beat that makes wptr==depth: go to READY, pattern_len=wptr+1.
  - truncated=1 if full without TLAST.
  - TREADY is low from the cycle after the depth-th beat.
- READY/DONE:
  - dout=idle_level, dout_en=0, TREADY=0.
  - clr -> IDLE: wptr=0, pattern_len=0, truncated=0, done=0.
- IDLE/LOAD: start is ignored. abort or clr in LOAD -> IDLE, data discarded.
- Start (in READY or DONE) accepted at cycle T:
  - Latch ckdiv and loops; done<=0.
  - T+1: dout=mem[0], dout_en=1, sample_tick=1, state RUN.
  - Sample k appears at T+1+k*(ckdiv+1) with a sample_tick pulse; each sample is held exactly ckdiv+1 clocks.
  - Buffer uses synchronous-read RAM; the implementation prefetches the next address so no sample is stretched, including at wrap and with ckdiv=0.
- End of pass:
  - After sample pattern_len-1 completes its period, pass_cnt++.
  - If loops!=0 and pass_cnt==loops: -> DONE next cycle (dout=idle_level, dout_en=0, done=1, no tick).
  - Otherwise wrap to sample 0 seamlessly.
- loops=0: play until abort. pass_cnt saturates; no wrap side-effects.
- abort in RUN: next cycle DONE, dout=idle_level, dout_en=0, done=1.
- Priority: abort beats start in the same cycle. start during RUN is ignored. ckdiv/loops changes during RUN are ignored.
- pattern_len=1: dout constant for the whole run; ticks still occur every ckdiv+1 clocks.
- Input stream beats arriving in READY/RUN/DONE are back-pressured (TREADY=0) and not lost.

Test Plan:
- Load 4 beats 0xA,0xB,0xC,0xD (TLAST on 4th); ckdiv=0, loops=2, start -> dout A,B,C,D,A,B,C,D on consecutive cycles from T+1, 8 ticks, then dout=idle_level, done=1, pattern_len=4.
- Same pattern, ckdiv=3, loops=1 -> each value held 4 clocks, ticks every 4 clocks, DONE at T+17.
- depth=8, stream 10 beats without TLAST -> 8 accepted, TREADY low after 8th, truncated=1, pattern_len=8, beats 9-10 remain pending.
- loops=0, ckdiv=1, 3-sample pattern, abort at the 20th clock -> continuous wrap with no gap at the seam; dout=idle_level and done=1 the cycle after abort; restart replays from sample 0.
- start and abort in the same cycle from READY -> stays non-running, done=1, dout_en=0; clr -> IDLE, loaded=0, TREADY=1.
- Assert S_AXI_ARESETN low mid-run -> dout=0, dout_en=0, loaded=0 immediately (asynchronous), state IDLE after release.
